// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, funct codes, command mnemonics and the
// field-packing helpers used by the instruction encoder and the control unit.
package mips_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SGT = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Symbolic command mnemonics carried on cmd_op
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SGT  = 5'd5,
    OP_XOR  = 5'd6,
    OP_NOR  = 5'd7,
    OP_SLL  = 5'd8,
    OP_SRL  = 5'd9,
    OP_ADDI = 5'd10,
    OP_ANDI = 5'd11,
    OP_ORI  = 5'd12,
    OP_XORI = 5'd13,
    OP_SLTI = 5'd14,
    OP_LW   = 5'd15,
    OP_SW   = 5'd16,
    OP_BEQ  = 5'd17,
    OP_BNE  = 5'd18,
    OP_J    = 5'd19,
    OP_JAL  = 5'd20,
    OP_JR   = 5'd21
  } cmd_op_e;

  // JR is refused along with the undefined codes: its opcode would alias ADDI
  // in the decoder, so it can never round-trip.
  function automatic logic is_invalid_op(input logic [4:0] op);
    return (op > OP_JAL);
  endfunction

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous word FIFO between the encoder and the instruction-memory
// write port. Head word reads as zero while empty so the port idles quietly.
module inst_fifo
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; clear drops everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: packs symbolic commands into MIPS machine
// words, buffers them, and writes them to instruction memory at an
// auto-incrementing word address.
module inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              im_valid,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              err_invalid,
  output logic [7:0]        err_count,
  output logic              addr_wrapped
);

  logic [31:0]       enc_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              cmd_accept;
  logic              cmd_bad;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic              err_invalid_q, err_invalid_d;
  logic [7:0]        err_count_q, err_count_d;

  // Restart wins over any handshake: no accept and no write in that cycle.
  assign cmd_ready  = !fifo_full && !restart;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign cmd_bad    = is_invalid_op(cmd_op);
  assign push       = cmd_accept && !cmd_bad;
  assign im_valid   = !fifo_empty;
  assign pop        = im_valid && im_ready && !restart;

  // Combinational field packing from the command mnemonic.
  always_comb begin
    enc_word = '0;
    case (cmd_op)
      OP_ADD:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_ADD);
      OP_SUB:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_SUB);
      OP_AND:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_AND);
      OP_OR:   enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_OR);
      OP_SLT:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_SLT);
      OP_SGT:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_SGT);
      OP_XOR:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_XOR);
      OP_NOR:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_NOR);
      OP_SLL:  enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, FN_SLL);
      OP_SRL:  enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, FN_SRL);
      OP_ADDI: enc_word = i_word(OPC_ADDI, cmd_rs, cmd_rt, cmd_imm);
      OP_ANDI: enc_word = i_word(OPC_ANDI, cmd_rs, cmd_rt, cmd_imm);
      OP_ORI:  enc_word = i_word(OPC_ORI,  cmd_rs, cmd_rt, cmd_imm);
      OP_XORI: enc_word = i_word(OPC_XORI, cmd_rs, cmd_rt, cmd_imm);
      OP_SLTI: enc_word = i_word(OPC_SLTI, cmd_rs, cmd_rt, cmd_imm);
      OP_LW:   enc_word = i_word(OPC_LW,   cmd_rs, cmd_rt, cmd_imm);
      OP_SW:   enc_word = i_word(OPC_SW,   cmd_rs, cmd_rt, cmd_imm);
      OP_BEQ:  enc_word = i_word(OPC_BEQ,  cmd_rs, cmd_rt, cmd_imm);
      OP_BNE:  enc_word = i_word(OPC_BNE,  cmd_rs, cmd_rt, cmd_imm);
      OP_J:    enc_word = j_word(OPC_J,   cmd_target);
      OP_JAL:  enc_word = j_word(OPC_JAL, cmd_target);
      default: enc_word = '0;
    endcase
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .pop_data  (im_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Address counter, wrap flag and rejected-command bookkeeping.
  always_comb begin
    addr_d        = addr_q;
    wrapped_d     = wrapped_q;
    err_invalid_d = 1'b0;
    err_count_d   = err_count_q;
    if (restart) begin
      addr_d      = BASE_ADDR;
      wrapped_d   = 1'b0;
      err_count_d = '0;
    end else begin
      if (pop) begin
        addr_d = addr_q + 1'b1;
        if (&addr_q) begin
          wrapped_d = 1'b1;
        end
      end
      if (cmd_accept && cmd_bad) begin
        err_invalid_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  // Control registers with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= BASE_ADDR;
      wrapped_q     <= 1'b0;
      err_invalid_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      addr_q        <= addr_d;
      wrapped_q     <= wrapped_d;
      err_invalid_q <= err_invalid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign im_addr      = addr_q;
  assign addr_wrapped = wrapped_q;
  assign err_invalid  = err_invalid_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder (ADDR_W=2, DEPTH=4): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_inst_encoder;

  localparam int DEPTH = 4;
  localparam int NADDR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        im_valid;
  logic        im_ready;
  logic [1:0]  im_addr;
  logic [31:0] im_data;
  logic        err_invalid;
  logic [7:0]  err_count;
  logic        addr_wrapped;

  int checks = 0;
  int errors = 0;

  // Reference tables taken from the ISA listing
  logic [5:0] fn_tab  [0:9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h29, 6'h26, 6'h27, 6'h00, 6'h02};
  logic [5:0] opc_tab [0:8] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05};

  // Reference model state
  logic [31:0] mq[$];
  int          m_addr;
  bit          m_wrap;
  int          m_errcnt;
  bit          m_errp;

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rs       (cmd_rs),
    .cmd_rt       (cmd_rt),
    .cmd_rd       (cmd_rd),
    .cmd_shamt    (cmd_shamt),
    .cmd_imm      (cmd_imm),
    .cmd_target   (cmd_target),
    .im_valid     (im_valid),
    .im_ready     (im_ready),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .err_invalid  (err_invalid),
    .err_count    (err_count),
    .addr_wrapped (addr_wrapped)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_encode(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] sh,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    if (op <= 7)  return {6'h00, rs, rt, rd, 5'd0, fn_tab[op]};
    if (op <= 9)  return {6'h00, 5'd0, rt, rd, sh, fn_tab[op]};
    if (op <= 18) return {opc_tab[op-10], rs, rt, imm};
    if (op == 19) return {6'h02, tgt};
    if (op == 20) return {6'h03, tgt};
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    cmd_op = 5'(op); cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_shamt = sh; cmd_imm = imm; cmd_target = tgt;
  endtask

  task automatic do_restart();
    cmd_valid = 1'b0;
    restart   = 1'b1;
    tick();
    restart   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0; cmd_valid = 1'b0; im_ready = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL reset_im_valid got %b want 0", im_valid); end
    checks++; if (im_addr !== 2'd0) begin errors++; $display("FAIL reset_im_addr got %0d want 0", im_addr); end
    checks++; if (im_data !== 32'h0) begin errors++; $display("FAIL reset_im_data got %h want 0", im_data); end
    checks++; if (err_invalid !== 1'b0 || err_count !== 8'd0 || addr_wrapped !== 1'b0) begin
      errors++; $display("FAIL reset_flags got err=%b cnt=%0d wrap=%b want 0 0 0", err_invalid, err_count, addr_wrapped);
    end
  endtask

  task automatic test_add();
    do_restart();
    im_ready = 1'b1;
    set_cmd(0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
    cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (im_valid !== 1'b1 || im_data !== 32'h00221820 || im_addr !== 2'd0) begin
      errors++; $display("FAIL add_word got v=%b %h @%0d want 1 00221820 @0", im_valid, im_data, im_addr);
    end
    tick();
    checks++; if (im_valid !== 1'b0 || im_addr !== 2'd1) begin
      errors++; $display("FAIL add_after got v=%b @%0d want 0 @1", im_valid, im_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_restart();
    im_ready = 1'b1;
    set_cmd(10, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    cmd_valid = 1'b1;
    tick();
    set_cmd(19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    checks++; if (im_data !== 32'h2008FFFF || im_addr !== 2'd0 || im_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got v=%b %h @%0d want 1 2008ffff @0", im_valid, im_data, im_addr);
    end
    tick();
    cmd_valid = 1'b0;
    checks++; if (im_data !== 32'h08000010 || im_addr !== 2'd1 || im_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got v=%b %h @%0d want 1 08000010 @1", im_valid, im_data, im_addr);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] w [5];
    int acc = 0;
    do_restart();
    im_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = ref_encode(12, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(16'h100 + i), 26'h0);
      set_cmd(12, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(16'h100 + i), 26'h0);
      cmd_valid = 1'b1;
      #1;
      if (cmd_ready === 1'b1) acc++;
      if (i > 0) begin
        checks++; if (im_data !== w[0]) begin errors++; $display("FAIL fill_head_stable got %h want %h", im_data, w[0]); end
      end
      tick();
    end
    cmd_valid = 1'b0;
    #1;
    checks++; if (acc != DEPTH) begin errors++; $display("FAIL fill_accepted got %0d want %0d", acc, DEPTH); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", cmd_ready); end
    im_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (im_valid !== 1'b1 || im_data !== w[i] || im_addr !== 2'(i)) begin
        errors++; $display("FAIL fill_drain%0d got v=%b %h @%0d want 1 %h @%0d", i, im_valid, im_data, im_addr, w[i], i);
      end
      tick();
    end
    checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %b want 0", im_valid); end
  endtask

  task automatic test_invalid();
    do_restart();
    im_ready = 1'b1;
    set_cmd(21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0);
    cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL inv_ready got %b want 1", cmd_ready); end
    tick();
    checks++; if (err_invalid !== 1'b1 || im_valid !== 1'b0) begin
      errors++; $display("FAIL inv_jr got err=%b v=%b want 1 0", err_invalid, im_valid);
    end
    set_cmd(25, 5'd4, 5'd5, 5'd6, 5'd1, 16'h0, 26'h0);
    tick();
    checks++; if (err_invalid !== 1'b1 || im_valid !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("FAIL inv_op25 got err=%b v=%b cnt=%0d want 1 0 2", err_invalid, im_valid, err_count);
    end
    set_cmd(8, 5'd9, 5'd4, 5'd5, 5'd2, 16'h0, 26'h0);
    tick();
    cmd_valid = 1'b0;
    checks++; if (err_invalid !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("FAIL inv_after got err=%b cnt=%0d want 0 2", err_invalid, err_count);
    end
    checks++; if (im_valid !== 1'b1 || im_data !== 32'h00042880 || im_addr !== 2'd0) begin
      errors++; $display("FAIL inv_sll got v=%b %h @%0d want 1 00042880 @0", im_valid, im_data, im_addr);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_restart();
    im_ready = 1'b1;
    set_cmd(30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    cmd_valid = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i == 200 || i == 255 || i == 260) begin
        checks++;
        if (err_count !== 8'((i > 255) ? 255 : i)) begin
          errors++; $display("FAIL sat_count@%0d got %0d want %0d", i, err_count, (i > 255) ? 255 : i);
        end
      end
    end
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    do_restart();
    im_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      cmd_valid = (i < 5);
      set_cmd(1, 5'(i), 5'd3, 5'd4, 5'd0, 16'h0, 26'h0);
      #1;
      if (i > 0) begin
        checks++; if (im_valid !== 1'b1 || im_addr !== 2'((i - 1) % NADDR)) begin
          errors++; $display("FAIL wrap_addr%0d got v=%b @%0d want 1 @%0d", i, im_valid, im_addr, (i - 1) % NADDR);
        end
        checks++; if (addr_wrapped !== ((i - 1) >= 4)) begin
          errors++; $display("FAIL wrap_flag%0d got %b want %b", i, addr_wrapped, ((i - 1) >= 4));
        end
      end
      tick();
    end
    checks++; if (addr_wrapped !== 1'b1 || im_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_sticky got wrap=%b v=%b want 1 0", addr_wrapped, im_valid);
    end
    set_cmd(0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    cmd_valid = 1'b1;
    restart   = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wrap_restart_ready got %b want 0", cmd_ready); end
    tick();
    restart   = 1'b0;
    cmd_valid = 1'b0;
    checks++; if (addr_wrapped !== 1'b0 || im_addr !== 2'd0 || im_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_restart got wrap=%b @%0d v=%b want 0 @0 0", addr_wrapped, im_addr, im_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_restart();
    im_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(2, 5'(i), 5'd1, 5'd2, 5'd0, 16'h0, 26'h0);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    im_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd((i == 3) ? 21 : 3, 5'(i), 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (im_valid !== 1'b1 || addr_wrapped !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL mid_pre got v=%b wrap=%b cnt=%0d want 1 1 1", im_valid, addr_wrapped, err_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (im_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async got v=%b rdy=%b want 0 1", im_valid, cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (im_valid !== 1'b0 || im_addr !== 2'd0 || err_count !== 8'd0 || addr_wrapped !== 1'b0 || err_invalid !== 1'b0) begin
      errors++; $display("FAIL mid_release got v=%b @%0d cnt=%0d wrap=%b err=%b want 0 @0 0 0 0",
                         im_valid, im_addr, err_count, addr_wrapped, err_invalid);
    end
  endtask

  task automatic test_random();
    bit exp_ready, acc, bad;
    int op;
    do_restart();
    mq.delete(); m_addr = 0; m_wrap = 0; m_errcnt = 0; m_errp = 0;
    for (int c = 0; c < 600; c++) begin
      checks++; if (err_invalid !== m_errp || err_count !== 8'(m_errcnt) || addr_wrapped !== m_wrap) begin
        errors++; $display("FAIL rnd_regs@%0d got err=%b cnt=%0d wrap=%b want %b %0d %b",
                           c, err_invalid, err_count, addr_wrapped, m_errp, m_errcnt, m_wrap);
      end
      restart   = ($urandom_range(0, 39) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      im_ready  = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 31);
      set_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      #1;
      exp_ready = !restart && (mq.size() < DEPTH);
      checks++; if (cmd_ready !== exp_ready || im_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_hs@%0d got rdy=%b v=%b want %b %b", c, cmd_ready, im_valid, exp_ready, (mq.size() > 0));
      end
      if (mq.size() > 0) begin
        checks++; if (im_data !== mq[0] || im_addr !== 2'(m_addr)) begin
          errors++; $display("FAIL rnd_word@%0d got %h @%0d want %h @%0d", c, im_data, im_addr, mq[0], m_addr);
        end
      end
      if (restart) begin
        mq.delete(); m_addr = 0; m_wrap = 0; m_errcnt = 0; m_errp = 0;
      end else begin
        acc = cmd_valid && exp_ready;
        bad = (op > 20);
        if (mq.size() > 0 && im_ready) begin
          void'(mq.pop_front());
          if (m_addr == NADDR - 1) m_wrap = 1;
          m_addr = (m_addr + 1) % NADDR;
        end
        if (acc && !bad) mq.push_back(ref_encode(op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_target));
        m_errp = acc && bad;
        if (m_errp && m_errcnt < 255) m_errcnt++;
      end
      tick();
    end
    restart = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_fill();
    test_invalid();
    test_saturate();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
